// File: rtl/m_bus_arbiter.sv
// -----------------------------------------------------------------------------
// m_bus_arbiter
//   Two-master, three-slave bus controller. Arbitrates the CPU data port (M0)
//   and a DMA/debug port (M1) onto the shared DM/TC1/TC2 slave bus. Only one
//   transaction is outstanding at a time.
//
//   Sequence: IDLE -> ADDR -> WAIT (RD_LAT-1 cycles) -> RESP -> IDLE.
//   Decode errors skip the slave access: IDLE -> RESP.
//
//   Handshake: a master raises mN_req with its fields stable. In an IDLE
//   cycle the arbiter pulses mN_gnt combinationally for one cycle, and the
//   fields are latched at the closing edge. Completion is a one-cycle
//   mN_rvalid pulse carrying mN_rdata/mN_err. There is no back-pressure on
//   the response. A req still high after its gnt counts as a new request.
//
//   Configuration macro: BUS_ARB_RR_EN
//     defined   : round-robin. On a tie, the master not granted last wins.
//     undefined : fixed priority. M0 always wins.
//
// Ports
//   clk, rst_n                clock, async active-low reset
//   mN_req/we/addr/byteen/wdata   master N request fields (N = 0, 1)
//   mN_gnt                    request accepted (combinational, IDLE only)
//   mN_rvalid/rdata/err       registered completion for master N
//   s_sel                     one-hot {TC2,TC1,DM}, high only in ADDR
//   s_we, s_byteen            write strobe / lanes, only in ADDR
//   s_addr, s_wdata           latched address / write data
//   dm_rdata/tc1_rdata/tc2_rdata  slave read data
//   dbg_state                 current FSM state
// -----------------------------------------------------------------------------
module m_bus_arbiter #(
   parameter int          RD_LAT   = 1,
   parameter logic [31:0] DM_END   = 32'h0000_2fff,
   parameter logic [31:0] TC1_BASE = 32'h0000_7f00,
   parameter logic [31:0] TC2_BASE = 32'h0000_7f10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [3:0]  m0_byteen,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [3:0]  m1_byteen,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic [2:0]  s_sel,
   output logic        s_we,
   output logic [31:0] s_addr,
   output logic [3:0]  s_byteen,
   output logic [31:0] s_wdata,
   input  logic [31:0] dm_rdata,
   input  logic [31:0] tc1_rdata,
   input  logic [31:0] tc2_rdata,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam int CW = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic          lat_mid;   // latched master id, 1 = M1
   logic          lat_we;
   logic [2:0]    lat_sel;

   // ---------------- arbitration ----------------
   logic any_req;
   logic win;                // 1 = M1 wins this cycle

   assign any_req = m0_req | m1_req;

`ifdef BUS_ARB_RR_EN
   logic rr_ptr;             // master that wins a tie (0 = M0)

   always_comb begin
      win = 1'b0;
      if (m0_req && m1_req) win = rr_ptr;
      else                  win = ~m0_req;
   end
`else
   always_comb begin
      win = ~m0_req;
   end
`endif

   assign m0_gnt = (state == IDLE) && any_req && !win;
   assign m1_gnt = (state == IDLE) && any_req &&  win;

   // ---------------- winner fields and decode ----------------
   logic        w_we;
   logic [31:0] w_addr;
   logic [3:0]  w_byteen;
   logic [31:0] w_wdata;

   always_comb begin
      w_we     = win ? m1_we     : m0_we;
      w_addr   = win ? m1_addr   : m0_addr;
      w_byteen = win ? m1_byteen : m0_byteen;
      w_wdata  = win ? m1_wdata  : m0_wdata;
   end

   logic       hit_dm, hit_tc1, hit_tc2, hit_tc, cnt_reg, w_err;
   logic [2:0] w_sel;

   always_comb begin
      hit_dm  = (w_addr <= DM_END);
      hit_tc1 = (w_addr >= TC1_BASE) && (w_addr <= TC1_BASE + 32'h0000_000b);
      hit_tc2 = (w_addr >= TC2_BASE) && (w_addr <= TC2_BASE + 32'h0000_000b);
      hit_tc  = hit_tc1 | hit_tc2;
      // Offset 0x8..0xb of a timer window is the read-only count register.
      cnt_reg = (hit_tc1 && (w_addr >= TC1_BASE + 32'h0000_0008)) ||
                (hit_tc2 && (w_addr >= TC2_BASE + 32'h0000_0008));
      w_err   = !(hit_dm | hit_tc)
              | (hit_tc && (w_byteen != 4'b1111))
              | (w_we && cnt_reg)
              | (w_we && (w_byteen == 4'b0000));
      w_sel   = {hit_tc2, hit_tc1, hit_dm};
   end

   // ---------------- response data ----------------
   // Slave data is taken at the edge that enters RESP. Writes return zero.
   logic [31:0] resp_data;

   always_comb begin
      resp_data = 32'h0;
      if (!lat_we) begin
         if      (lat_sel[0]) resp_data = dm_rdata;
         else if (lat_sel[1]) resp_data = tc1_rdata;
         else if (lat_sel[2]) resp_data = tc2_rdata;
      end
   end

   assign dbg_state = state;

   // ---------------- FSM and registered outputs ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         lat_mid   <= 1'b0;
         lat_we    <= 1'b0;
         lat_sel   <= 3'b000;
         s_sel     <= 3'b000;
         s_we      <= 1'b0;
         s_addr    <= 32'h0;
         s_byteen  <= 4'h0;
         s_wdata   <= 32'h0;
         m0_rvalid <= 1'b0;
         m0_rdata  <= 32'h0;
         m0_err    <= 1'b0;
         m1_rvalid <= 1'b0;
         m1_rdata  <= 32'h0;
         m1_err    <= 1'b0;
`ifdef BUS_ARB_RR_EN
         rr_ptr    <= 1'b0;
`endif
      end else begin
         // Slave strobes and responses are single-cycle pulses.
         s_sel     <= 3'b000;
         s_we      <= 1'b0;
         s_byteen  <= 4'h0;
         m0_rvalid <= 1'b0;
         m0_rdata  <= 32'h0;
         m0_err    <= 1'b0;
         m1_rvalid <= 1'b0;
         m1_rdata  <= 32'h0;
         m1_err    <= 1'b0;

         case (state)
            IDLE: begin
               if (any_req) begin
                  lat_mid <= win;
                  lat_we  <= w_we;
                  lat_sel <= w_sel;
                  s_addr  <= w_addr;
                  s_wdata <= w_wdata;
`ifdef BUS_ARB_RR_EN
                  rr_ptr  <= ~win;
`endif
                  if (w_err) begin
                     state     <= RESP;
                     m0_rvalid <= ~win;
                     m0_err    <= ~win;
                     m1_rvalid <= win;
                     m1_err    <= win;
                  end else begin
                     state    <= ADDR;
                     s_sel    <= w_sel;
                     s_we     <= w_we;
                     s_byteen <= w_we ? w_byteen : 4'h0;
                  end
               end
            end

            ADDR: begin
               if (RD_LAT == 1) begin
                  state     <= RESP;
                  m0_rvalid <= ~lat_mid;
                  m0_rdata  <= lat_mid ? 32'h0 : resp_data;
                  m1_rvalid <= lat_mid;
                  m1_rdata  <= lat_mid ? resp_data : 32'h0;
               end else begin
                  state    <= WAIT;
                  wait_cnt <= '0;
               end
            end

            WAIT: begin
               if (wait_cnt == CW'(RD_LAT - 2)) begin
                  state     <= RESP;
                  m0_rvalid <= ~lat_mid;
                  m0_rdata  <= lat_mid ? 32'h0 : resp_data;
                  m1_rvalid <= lat_mid;
                  m1_rdata  <= lat_mid ? resp_data : 32'h0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            RESP: begin
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_m_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_m_bus_arbiter
//   Directed bench for m_bus_arbiter. The main instance uses RD_LAT=1 with a
//   small DM memory model and fixed timer read data. A second instance with
//   RD_LAT=3 checks the longer read latency. Expected completions are queued
//   at grant time and checked by a monitor when rvalid appears.
// -----------------------------------------------------------------------------
module tb_m_bus_arbiter;

   localparam int RD_LAT = 1;
   localparam logic [31:0] TC1_VAL = 32'h0000_1234;
   localparam logic [31:0] TC2_VAL = 32'hcafe_0002;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main DUT signals ----------------
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_byteen, m1_byteen;
   logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic [2:0]  s_sel;
   logic        s_we;
   logic [31:0] s_addr, s_wdata;
   logic [3:0]  s_byteen;
   logic [31:0] dm_rdata, tc1_rdata, tc2_rdata;
   logic [1:0]  dbg_state;

   m_bus_arbiter #(.RD_LAT(RD_LAT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_byteen(m0_byteen),
      .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
      .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_byteen(m1_byteen),
      .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
      .m1_rdata(m1_rdata), .m1_err(m1_err),
      .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_byteen(s_byteen),
      .s_wdata(s_wdata), .dm_rdata(dm_rdata), .tc1_rdata(tc1_rdata),
      .tc2_rdata(tc2_rdata), .dbg_state(dbg_state)
   );

   // ---------------- RD_LAT=3 DUT signals ----------------
   logic        b_m1_req;
   logic [31:0] b_m1_addr;
   logic        b_m0_gnt, b_m0_rvalid, b_m0_err, b_m1_gnt, b_m1_rvalid, b_m1_err;
   logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
   logic [2:0]  b_s_sel;
   logic        b_s_we;
   logic [3:0]  b_s_byteen;
   logic [1:0]  b_dbg_state;

   m_bus_arbiter #(.RD_LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .m0_req(1'b0), .m0_we(1'b0), .m0_addr(32'h0), .m0_byteen(4'h0),
      .m0_wdata(32'h0), .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid),
      .m0_rdata(b_m0_rdata), .m0_err(b_m0_err),
      .m1_req(b_m1_req), .m1_we(1'b0), .m1_addr(b_m1_addr), .m1_byteen(4'hf),
      .m1_wdata(32'h0), .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid),
      .m1_rdata(b_m1_rdata), .m1_err(b_m1_err),
      .s_sel(b_s_sel), .s_we(b_s_we), .s_addr(b_s_addr), .s_byteen(b_s_byteen),
      .s_wdata(b_s_wdata), .dm_rdata(32'h0), .tc1_rdata(TC1_VAL),
      .tc2_rdata(32'h0), .dbg_state(b_dbg_state)
   );

   // ---------------- slave models ----------------
   logic [31:0] dm_mem [16];
   assign dm_rdata  = dm_mem[s_addr[5:2]];
   assign tc1_rdata = TC1_VAL;
   assign tc2_rdata = TC2_VAL;

   always @(posedge clk) begin
      if (s_sel[0] && s_we) begin
         for (int b = 0; b < 4; b++)
            if (s_byteen[b]) dm_mem[s_addr[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
      end
   end

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_bad = 0;
   logic [33:0] exp_q[$];   // {master id, err, rdata}

   task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [33:0] got;
      if (m0_rvalid || m1_rvalid) begin
         got = {m1_rvalid, (m1_rvalid ? m1_err : m0_err), (m1_rvalid ? m1_rdata : m0_rdata)};
         if (m0_rvalid && m1_rvalid) check("rvalid_both", 34'h1, 34'h0);
         if (exp_q.size() == 0) check("unexpected_rvalid", got, 34'h0);
         else check("response", got, exp_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic m, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
      if (m) begin
         m1_we = we; m1_addr = addr; m1_byteen = be; m1_wdata = wd; m1_req = 1'b1;
      end else begin
         m0_we = we; m0_addr = addr; m0_byteen = be; m0_wdata = wd; m0_req = 1'b1;
      end
   endtask

   task automatic txn(input string name, input logic m, input logic we,
                      input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                      input logic [2:0] exp_sel, input logic exp_err, input logic [31:0] exp_rd);
      logic got_g;
      @(posedge clk); #1;
      drive(m, we, addr, be, wd);
      got_g = 1'b0;
      for (int i = 0; i < 8 && !got_g; i++) begin
         @(negedge clk);
         got_g = m ? m1_gnt : m0_gnt;
      end
      check({name, "_gnt"}, {33'h0, got_g}, 34'h1);
      if (got_g) exp_q.push_back({m, exp_err, exp_rd});
      @(posedge clk); #1;
      m0_req = 1'b0; m1_req = 1'b0;
      if (!got_g) return;
      @(negedge clk);
      check({name, "_sel"}, {30'h0, s_we, s_sel}, {30'h0, (exp_sel != 3'b000) ? we : 1'b0, exp_sel});
      if (!exp_err) repeat (RD_LAT) @(negedge clk);
      check({name, "_lat"}, {33'h0, (m ? m1_rvalid : m0_rvalid)}, 34'h1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic rr;
      int   cnt;
      logic got_g;
`ifdef BUS_ARB_RR_EN
      rr = 1'b1;
`else
      rr = 1'b0;
`endif
      for (int i = 0; i < 16; i++) dm_mem[i] = 32'h0;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_byteen = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_byteen = 0; m1_wdata = 0;
      b_m1_req = 0; b_m1_addr = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset_outputs",
            {24'h0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_sel, s_we, dbg_state},
            34'h0);

      // Normal accesses.
      txn("wr_dm",      0, 1, 32'h0000_0010, 4'hf, 32'hdead_beef, 3'b001, 0, 32'h0);
      check("dm_word4", {2'b0, dm_mem[4]}, {2'b0, 32'hdead_beef});
      txn("rd_dm",      0, 0, 32'h0000_0010, 4'hf, 32'h0,         3'b001, 0, 32'hdead_beef);
      txn("rd_tc1",     1, 0, 32'h0000_7f04, 4'hf, 32'h0,         3'b010, 0, TC1_VAL);
      txn("rd_tc2",     1, 0, 32'h0000_7f14, 4'hf, 32'h0,         3'b100, 0, TC2_VAL);
      txn("rd_tc1_cnt", 1, 0, 32'h0000_7f08, 4'hf, 32'h0,         3'b010, 0, TC1_VAL);
      txn("wr_dm_end",  0, 1, 32'h0000_2ffc, 4'h3, 32'h1111_abcd, 3'b001, 0, 32'h0);
      check("dm_word15", {2'b0, dm_mem[15]}, {2'b0, 32'h0000_abcd});

      // Error accesses: no slave select, rvalid one cycle after gnt.
      txn("err_tc_be",   0, 1, 32'h0000_7f00, 4'h1, 32'h0, 3'b000, 1, 32'h0);
      txn("err_tc2_cnt", 0, 1, 32'h0000_7f18, 4'hf, 32'h0, 3'b000, 1, 32'h0);
      txn("err_nowin",   0, 0, 32'h0000_3000, 4'hf, 32'h0, 3'b000, 1, 32'h0);
      txn("err_gap",     1, 0, 32'h0000_7f0c, 4'hf, 32'h0, 3'b000, 1, 32'h0);
      txn("err_tc1_cnt", 1, 1, 32'h0000_7f08, 4'hf, 32'h0, 3'b000, 1, 32'h0);
      txn("err_be0",     0, 1, 32'h0000_0020, 4'h0, 32'h0, 3'b000, 1, 32'h0);

      // Reset during ADDR of a write: strobes drop at once, nothing completes.
      @(posedge clk); #1;
      drive(0, 1, 32'h0000_0030, 4'hf, 32'h55aa_55aa);
      @(negedge clk);
      check("rst_gnt", {33'h0, m0_gnt}, 34'h1);
      @(posedge clk); #1;
      m0_req = 1'b0;
      check("rst_pre_sel", {30'h0, s_we, s_sel}, {30'h0, 1'b1, 3'b001});
      #2 rst_n = 1'b0;
      #1 check("rst_async_sel", {28'h0, dbg_state, s_we, s_sel}, 34'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_no_write", {2'b0, dm_mem[12]}, 34'h0);

      // Both masters hold req for six transactions.
      @(posedge clk); #1;
      drive(0, 0, 32'h0000_0000, 4'hf, 32'h0);
      drive(1, 0, 32'h0000_7f04, 4'hf, 32'h0);
      for (int k = 0; k < 6; k++) begin
         got_g = 1'b0;
         for (int i = 0; i < 8 && !got_g; i++) begin
            @(negedge clk);
            got_g = m0_gnt | m1_gnt;
         end
         check($sformatf("arb_%0d", k), {32'h0, m1_gnt, m0_gnt},
               {32'h0, (rr && k[0]) ? 2'b10 : 2'b01});
         if (got_g) exp_q.push_back({m1_gnt, 1'b0, m1_gnt ? TC1_VAL : 32'h0});
      end
      @(posedge clk); #1;
      m0_req = 1'b0; m1_req = 1'b0;
      repeat (4) @(negedge clk);

      // RD_LAT=3 read latency on the second instance.
      @(posedge clk); #1;
      b_m1_addr = 32'h0000_7f04; b_m1_req = 1'b1;
      got_g = 1'b0;
      for (int i = 0; i < 8 && !got_g; i++) begin
         @(negedge clk);
         got_g = b_m1_gnt;
      end
      check("lat3_gnt", {33'h0, got_g}, 34'h1);
      @(posedge clk); #1;
      b_m1_req = 1'b0;
      @(negedge clk);
      check("lat3_sel", {31'h0, b_s_sel}, {31'h0, 3'b010});
      cnt = 1;
      while (!b_m1_rvalid && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      check("lat3_cycles", 34'(cnt), 34'd4);
      check("lat3_rdata", {1'b0, b_m1_err, b_m1_rdata}, {2'b0, TC1_VAL});

      repeat (3) @(negedge clk);
      check("queue_drained", 34'(exp_q.size()), 34'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      n_bad++;
      $display("FAIL watchdog: got timeout want completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $fatal(1, "watchdog");
   end

endmodule
